// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war round/match controller.
package tow_pkg;

   typedef enum logic [1:0] {PLAY, POINT, MATCH_END} tow_state_e;

   localparam logic [9:0] LFSR_SEED = 10'h001;
   // Fibonacci taps for x^10 + x^7 + 1 (register bits 9 and 6)
   localparam logic [9:0] LFSR_TAPS = 10'h240;

endpackage

// File: rtl/tow_lfsr10.sv
// 10-bit Fibonacci LFSR, steps every cycle, reloads the seed on reset.
module tow_lfsr10
   import tow_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   output logic [9:0] lfsr_o
);

   logic [9:0] lfsr_q;

   always_ff @(posedge clk) begin
      if (reset) lfsr_q <= LFSR_SEED;
      else       lfsr_q <= {lfsr_q[8:0], ^(lfsr_q & LFSR_TAPS)};
   end

   assign lfsr_o = lfsr_q;

endmodule

// File: rtl/tug_of_war_ctrl.sv
// Tug-of-war round/match controller: light position, point hold, scores, match end.
// Optional CPU right-hand opponent is enabled with `define CPU_OPPONENT_EN.
module tug_of_war_ctrl
   import tow_pkg::*;
#(
   parameter int N_LIGHTS    = 9,
   parameter int SCORE_W     = 3,
   parameter int HOLD_CYCLES = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                L,
   input  logic                R,
`ifdef CPU_OPPONENT_EN
   input  logic                cpu_mode,
`endif
   output logic [N_LIGHTS-1:0] lights,
   output logic                game_over,
   output logic                winner_l,
   output logic                winner_r,
   output logic [SCORE_W-1:0]  score_l,
   output logic [SCORE_W-1:0]  score_r,
   output logic                match_over
);

   localparam int PW = $clog2(N_LIGHTS);
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam logic [PW-1:0]      CENTER_POS = PW'(N_LIGHTS / 2);
   localparam logic [PW-1:0]      LEFT_POS   = PW'(N_LIGHTS - 1);
   localparam logic [HW-1:0]      HOLD_LAST  = HW'(HOLD_CYCLES - 1);
   // a winning point taken from this score saturates the counter and ends the match
   localparam logic [SCORE_W-1:0] SCORE_PRE  = SCORE_W'((1 << SCORE_W) - 2);

   tow_state_e         state_q;
   logic [PW-1:0]      pos_q;
   logic [HW-1:0]      hold_q;
   logic [SCORE_W-1:0] score_l_q, score_r_q;
   logic               win_l_q, win_r_q;
   logic               r_press;

`ifdef CPU_OPPONENT_EN
   logic [9:0] lfsr;

   tow_lfsr10 u_lfsr (
      .clk    (clk),
      .reset  (reset),
      .lfsr_o (lfsr)
   );

   assign r_press = cpu_mode ? ((lfsr & 10'h00F) == 10'h000) : R;
`else
   assign r_press = R;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= PLAY;
         pos_q     <= CENTER_POS;
         hold_q    <= '0;
         score_l_q <= '0;
         score_r_q <= '0;
         win_l_q   <= 1'b0;
         win_r_q   <= 1'b0;
      end else begin
         case (state_q)
            PLAY: begin
               if (L && !r_press) begin
                  if (pos_q == LEFT_POS) begin
                     score_l_q <= score_l_q + 1'b1;
                     win_l_q   <= 1'b1;
                     win_r_q   <= 1'b0;
                     hold_q    <= '0;
                     state_q   <= (score_l_q == SCORE_PRE) ? MATCH_END : POINT;
                  end else begin
                     pos_q <= pos_q + 1'b1;
                  end
               end else if (r_press && !L) begin
                  if (pos_q == '0) begin
                     score_r_q <= score_r_q + 1'b1;
                     win_l_q   <= 1'b0;
                     win_r_q   <= 1'b1;
                     hold_q    <= '0;
                     state_q   <= (score_r_q == SCORE_PRE) ? MATCH_END : POINT;
                  end else begin
                     pos_q <= pos_q - 1'b1;
                  end
               end
            end
            POINT: begin
               if (hold_q == HOLD_LAST) begin
                  state_q <= PLAY;
                  pos_q   <= CENTER_POS;
               end else begin
                  hold_q <= hold_q + 1'b1;
               end
            end
            MATCH_END: ;
            default: state_q <= PLAY;
         endcase
      end
   end

   logic [N_LIGHTS-1:0] onehot;
   assign onehot = {{(N_LIGHTS-1){1'b0}}, 1'b1} << pos_q;

   assign lights     = (state_q == PLAY) ? onehot : '1;
   assign game_over  = (state_q != PLAY);
   assign match_over = (state_q == MATCH_END);
   assign winner_l   = win_l_q;
   assign winner_r   = win_r_q;
   assign score_l    = score_l_q;
   assign score_r    = score_r_q;

endmodule
